// File: rtl/mult_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_iter
// Purpose  : HI/LO multiply, multiply-accumulate and radix-2 restoring divide.
// Revision : 1.0
// ============================================================================
module mult_div_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       we_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             restore_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div0_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_MAX = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]     bk_hi_q, bk_hi_d, bk_lo_q, bk_lo_d;
  logic [2*WIDTH-1:0]   mres_q, mres_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic                 we_vld, start_ok, op_is_div, sgn;
  logic [2*WIDTH-1:0]   ext_a, ext_b, prod, base, mres_new;
  logic [WIDTH-1:0]     a_mag, b_mag, rem_s, quo_s;
  logic [WIDTH:0]       shifted, diff;
  logic                 ge;
  logic                 comp_wr;
  logic [WIDTH-1:0]     res_hi, res_lo;

  assign we_vld    = (we_i == 2'b01) || (we_i == 2'b10);
  assign op_is_div = (op_i[2:1] == 2'b01);
  assign sgn       = ~op_i[0];
  assign start_ok  = start_i && (state_q == S_IDLE) && !restore_i && !we_vld;

  // Sign- or zero-extend to 2*WIDTH so one multiplier serves both signednesses.
  assign ext_a = {{WIDTH{sgn & a_i[WIDTH-1]}}, a_i};
  assign ext_b = {{WIDTH{sgn & b_i[WIDTH-1]}}, b_i};
  assign prod  = ext_a * ext_b;
  assign base  = {hi_q, lo_q};

  always_comb begin
    case (op_i[2:1])
      2'b10:   mres_new = base + prod;
      2'b11:   mres_new = base - prod;
      default: mres_new = prod;
    endcase
  end

  assign a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign ge      = ~diff[WIDTH];

  // With a zero divisor the remainder path shifts |a| through untouched,
  // so re-applying the dividend sign returns the original a.
  assign rem_s = rneg_q ? -rem_q : rem_q;
  assign quo_s = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -quo_q : quo_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mres_d  = mres_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    comp_wr = 1'b0;
    res_hi  = '0;
    res_lo  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (op_is_div) begin
            state_d = S_DIV;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            rneg_d  = sgn && a_i[WIDTH-1];
            dz_d    = (b_i == '0);
          end else begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(1);
            mres_d  = mres_new;
          end
        end
      end
      S_MUL: begin
        if (cnt_q == MUL_LAST) begin
          comp_wr = 1'b1;
          res_hi  = mres_q[2*WIDTH-1:WIDTH];
          res_lo  = mres_q[WIDTH-1:0];
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DIV: begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == DIV_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        comp_wr = 1'b1;
        res_hi  = rem_s;
        res_lo  = quo_s;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (cancel_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      comp_wr = 1'b0;
    end
  end

  // Restore outranks every write; an mthi/mtlo wins only its own half.
  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    bk_hi_d = bk_hi_q;
    bk_lo_d = bk_lo_q;
    if (restore_i) begin
      hi_d = bk_hi_q;
      lo_d = bk_lo_q;
    end else if (we_vld || comp_wr) begin
      bk_hi_d = hi_q;
      bk_lo_d = lo_q;
      if (we_i == 2'b01)  hi_d = wd_i;
      else if (comp_wr)   hi_d = res_hi;
      if (we_i == 2'b10)  lo_d = wd_i;
      else if (comp_wr)   lo_d = res_lo;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      bk_hi_q <= '0;
      bk_lo_q <= '0;
      mres_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      bk_hi_q <= bk_hi_d;
      bk_lo_q <= bk_lo_d;
      mres_q  <= mres_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = comp_wr;
  assign div0_o = comp_wr && (state_q == S_FIX) && dz_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_iter
// Purpose  : Scoreboard bench for mult_div_iter against an arithmetic model.
// Revision : 1.0
// ============================================================================
module tb_mult_div_iter;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0, wd_i = '0;
  logic [1:0]  we_i = '0;
  logic        restore_i = 1'b0, cancel_i = 1'b0;
  logic        busy_o, done_o, div0_o;
  logic [31:0] hi_o, lo_o;

  mult_div_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .we_i(we_i), .wd_i(wd_i), .restore_i(restore_i),
    .cancel_i(cancel_i), .busy_o(busy_o), .done_o(done_o), .div0_o(div0_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dz;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  bit          chk_pend = 0;
  bit          ignore_done = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_hi = '0, m_lo = '0, m_bk_hi = '0, m_bk_lo = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] hl,
                                         output bit dz);
    longint sa, sb, ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    dz = 0;
    if (op[2:1] == 2'b01) begin
      if (b == 32'd0) begin
        dz = 1;
        return {a, 32'hFFFF_FFFF};
      end
      if (!op[0]) return {32'(sa % sb), 32'(sa / sb)};
      return {32'(ua % ub), 32'(ua / ub)};
    end
    p = op[0] ? ua * ub : sa * sb;
    case (op[2:1])
      2'b10:   return hl + 64'(p);
      2'b11:   return hl - 64'(p);
      default: return 64'(p);
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (chk_pend) begin
      check("sb_hi", {32'd0, hi_o}, {32'd0, cur.hi});
      check("sb_lo", {32'd0, lo_o}, {32'd0, cur.lo});
      chk_pend = 0;
    end
    if (reset_n_i && done_o && !ignore_done) begin
      if (sbq.size() == 0) begin
        check("done_unexpected", {63'd0, done_o}, 64'd0);
      end else begin
        cur = sbq.pop_front();
        check("sb_div0", {63'd0, div0_o}, {63'd0, cur.dz});
        check("sb_done_cycle", 64'(cyc), 64'(cur.due));
        check("sb_busy_at_done", {63'd0, busy_o}, 64'd1);
        chk_pend = 1;
      end
    end
  end

  // Called at a negedge; returns at the first negedge with busy low.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    bit          dz;
    logic [63:0] r;
    int          lat, bcnt;
    r     = ref_op(op, a, b, {m_hi, m_lo}, dz);
    lat   = (op[2:1] == 2'b01) ? 33 : 5;
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.dz  = dz;
    e.due = cyc + lat;
    sbq.push_back(e);
    m_bk_hi = m_hi; m_bk_lo = m_lo;
    m_hi = r[63:32]; m_lo = r[31:0];
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    bcnt = 0;
    while (busy_o && bcnt < 200) begin
      bcnt++;
      @(negedge clk_i);
    end
    check("busy_cycles", 64'(bcnt), 64'(lat));
  endtask

  task automatic start_only(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic mt(input logic [1:0] we, input logic [31:0] d);
    we_i = we; wd_i = d;
    if (we == 2'b01 || we == 2'b10) begin
      m_bk_hi = m_hi; m_bk_lo = m_lo;
      if (we == 2'b01) m_hi = d;
      else             m_lo = d;
    end
    @(negedge clk_i);
    we_i = 2'b00;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, {32'd0, hi_o}, {32'd0, eh});
    check({name, "_lo"}, {32'd0, lo_o}, {32'd0, el});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    repeat (2) @(negedge clk_i);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_div0", {63'd0, div0_o}, 64'd0);
    check_hilo("rst", 32'd0, 32'd0);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    issue(3'b000, 32'hFFFF_FFFD, 32'd7);
    check_hilo("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2);
    check_hilo("div_m7d2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(3'b011, 32'd7, 32'd0);
    check_hilo("divu_7d0", 32'd7, 32'hFFFF_FFFF);

    mt(2'b01, 32'd0);
    mt(2'b10, 32'd10);
    issue(3'b100, 32'd2, 32'd3);
    check_hilo("madd", 32'd0, 32'd16);
    mt(2'b01, 32'd0);
    mt(2'b10, 32'd0);
    issue(3'b111, 32'd1, 32'd1);
    check_hilo("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    mt(2'b01, 32'd5);
    check("mthi_5", {32'd0, hi_o}, 64'd5);
    restore_i = 1'b1;
    m_hi = m_bk_hi; m_lo = m_bk_lo;
    @(negedge clk_i);
    restore_i = 1'b0;
    check_hilo("restore", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Divide cancelled in its tenth busy cycle.
    start_only(3'b010, 32'd1000, 32'd3);
    repeat (9) @(negedge clk_i);
    check("cancel_busy_before", {63'd0, busy_o}, 64'd1);
    cancel_i = 1'b1;
    @(negedge clk_i);
    cancel_i = 1'b0;
    check("cancel_busy_after", {63'd0, busy_o}, 64'd0);
    repeat (40) @(negedge clk_i);
    check_hilo("cancel", m_hi, m_lo);

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    check_hilo("div_min_m1", 32'd0, 32'h8000_0000);

    // mtlo in the completion cycle of a multiply: LO from mtlo, HI from product.
    ignore_done = 1;
    start_only(3'b001, 32'h0001_0000, 32'h0003_0000);
    repeat (4) @(negedge clk_i);
    check("we_comp_done", {63'd0, done_o}, 64'd1);
    mt(2'b10, 32'hCAFE_F00D);
    ignore_done = 0;
    m_hi = 32'd3; m_lo = 32'hCAFE_F00D;
    check_hilo("we_comp", 32'd3, 32'hCAFE_F00D);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      issue(rop, ra, rb);
    end

    // Asynchronous reset in the middle of a divide.
    start_only(3'b011, 32'hDEAD_BEEF, 32'd17);
    repeat (6) @(negedge clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check_hilo("arst", 32'd0, 32'd0);
    m_hi = '0; m_lo = '0; m_bk_hi = '0; m_bk_lo = '0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    issue(3'b011, 32'd100, 32'd7);
    check_hilo("post_rst_divu", 32'd2, 32'd14);

    repeat (3) @(negedge clk_i);
    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
